// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin sharing of one combinational FP adder across NUM_REQ requesters, two-stage pipeline
module fp_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_op1,
  input  logic [32*NUM_REQ-1:0] req_op2,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [31:0]           add_operand1,
  output logic [31:0]           add_operand2,
  input  logic [31:0]           add_result,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_data,
  output logic [ID_W-1:0]       rsp_id,
  input  logic                  rsp_ready
);
  logic            s1_valid;
  logic [ID_W-1:0] s1_id;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] win;
  logic [ID_W-1:0] idx;
  logic            found;
  logic            rsp_free;
  logic            s1_free;
  logic            take;
  assign rsp_free = !rsp_valid || rsp_ready;
  assign s1_free  = !s1_valid || rsp_free;
  // walk the ring starting just past the previous winner
  always_comb begin
    idx   = last_grant;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (idx == ID_W'(NUM_REQ - 1)) ? '0 : idx + ID_W'(1);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end
  assign req_ready = (found && s1_free && !rst) ? NUM_REQ'(1) << win : '0;
  assign take      = |req_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_id        <= '0;
      last_grant   <= ID_W'(NUM_REQ - 1);
      add_operand1 <= '0;
      add_operand2 <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_id       <= '0;
    end else begin
      if (rsp_free) begin
        rsp_valid <= s1_valid;
        if (s1_valid) begin
          rsp_data <= add_result;
          rsp_id   <= s1_id;
        end
      end
      if (s1_free) begin
        s1_valid <= take;
        if (take) begin
          add_operand1 <= req_op1[{win, 5'd0} +: 32];
          add_operand2 <= req_op2[{win, 5'd0} +: 32];
          s1_id        <= win;
          last_grant   <= win;
        end
      end
    end
  end
endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb_fp_add_arbiter: table-driven and directed checks of the shared-adder arbiter with a lookup-table stand-in adder
module tb_fp_add_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_op1;
  logic [127:0] req_op2;
  logic [3:0]   req_ready;
  logic [31:0]  add_operand1;
  logic [31:0]  add_operand2;
  logic [31:0]  add_result;
  logic         rsp_valid;
  logic [31:0]  rsp_data;
  logic [1:0]   rsp_id;
  logic         rsp_ready;
  int tests = 0;
  int fails = 0;

  fp_add_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op1(req_op1), .req_op2(req_op2),
    .req_ready(req_ready), .add_operand1(add_operand1), .add_operand2(add_operand2),
    .add_result(add_result), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  // hand-computed IEEE-754 sums for the operand pairs used here
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h40000000}: return 32'h40400000;
      {32'h3F800000, 32'h3F800000}: return 32'h40000000;
      {32'h40000000, 32'h40000000}: return 32'h40800000;
      {32'h3F000000, 32'h3F000000}: return 32'h3F800000;
      {32'h3F800000, 32'h3F000000}: return 32'h3FC00000;
      {32'h00000000, 32'hC0400000}: return 32'hC0400000;
      default:                      return 32'hBAD00000;
    endcase
  endfunction
  assign add_result = fadd(add_operand1, add_operand2);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_op1[32*i +: 32] = a;
    req_op2[32*i +: 32] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic default_ops();
    set_op(0, 32'h3F800000, 32'h40000000);
    set_op(1, 32'h3F800000, 32'h3F800000);
    set_op(2, 32'h40000000, 32'h40000000);
    set_op(3, 32'h3F000000, 32'h3F000000);
  endtask

  typedef struct {
    logic [3:0]  v;
    logic        rr;
    logic [3:0]  rdy;
    logic        rv;
    logic [1:0]  id;
    logic [31:0] d;
  } vec_t;
  vec_t tbl[16];

  initial begin
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 32'h0};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b0, 2'd0, 32'h0};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd0, 32'h40400000};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd1, 32'h40000000};
    tbl[4]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd2, 32'h40800000};
    tbl[5]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd3, 32'h3F800000};
    tbl[6]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 32'h40400000};
    tbl[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 32'h40800000};
    tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0};
    tbl[9]  = '{4'b0011, 1'b0, 4'b0001, 1'b0, 2'd0, 32'h0};
    tbl[10] = '{4'b0011, 1'b0, 4'b0010, 1'b0, 2'd0, 32'h0};
    tbl[11] = '{4'b0011, 1'b0, 4'b0000, 1'b1, 2'd0, 32'h40400000};
    tbl[12] = '{4'b0011, 1'b0, 4'b0000, 1'b1, 2'd0, 32'h40400000};
    tbl[13] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 32'h40400000};
    tbl[14] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 32'h40000000};
    tbl[15] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0};

    rst = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    req_op1 = '0;
    req_op2 = '0;
    default_ops();
    step();
    #1;
    chk("ready_in_reset", 32'(req_ready), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_data", rsp_data, 32'h0);
    chk("reset_rsp_id", 32'(rsp_id), 32'h0);
    chk("reset_op1", add_operand1, 32'h0);
    chk("reset_op2", add_operand2, 32'h0);
    rst = 1'b0;
    req_valid = '0;

    for (int i = 0; i < 16; i++) begin
      req_valid = tbl[i].v;
      rsp_ready = tbl[i].rr;
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].rv));
      if (tbl[i].rv) begin
        chk($sformatf("vec%0d_rsp_id", i), 32'(rsp_id), 32'(tbl[i].id));
        chk($sformatf("vec%0d_rsp_data", i), rsp_data, tbl[i].d);
      end
      step();
    end

    // single transfer from requester 2, 2-cycle latency
    do_reset();
    set_op(2, 32'h3F800000, 32'h40000000);
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    #1;
    chk("single_ready", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    chk("single_not_yet", 32'(rsp_valid), 32'h0);
    step();
    chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("single_rsp_data", rsp_data, 32'h40400000);
    chk("single_rsp_id", 32'(rsp_id), 32'h2);

    // zero operand passes through the adder untouched
    set_op(0, 32'h00000000, 32'hC0400000);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    step();
    chk("zero_rsp_data", rsp_data, 32'hC0400000);
    chk("zero_rsp_id", 32'(rsp_id), 32'h0);

    // backpressure with operands held stable during the stall
    do_reset();
    default_ops();
    rsp_ready = 1'b0;
    req_valid = 4'b0011;
    step();
    step();
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_ready", 32'(req_ready), 32'h0);
      chk("stall_op1", add_operand1, 32'h3F800000);
      chk("stall_op2", add_operand2, 32'h3F800000);
      chk("stall_rsp_id", 32'(rsp_id), 32'h0);
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    #1;
    chk("drain0_data", rsp_data, 32'h40400000);
    step();
    chk("drain1_valid", 32'(rsp_valid), 32'h1);
    chk("drain1_id", 32'(rsp_id), 32'h1);
    chk("drain1_data", rsp_data, 32'h40000000);
    step();
    chk("drain_empty", 32'(rsp_valid), 32'h0);

    // starvation: requester 1 joins requester 3
    do_reset();
    req_valid = 4'b1000;
    #1;
    chk("starve_g0", 32'(req_ready), 32'h8);
    step();
    req_valid = 4'b1010;
    #1;
    chk("starve_g1", 32'(req_ready), 32'h2);
    step();
    chk("starve_g2", 32'(req_ready), 32'h8);
    step();
    chk("starve_g3", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;

    // reset one cycle after an accept discards the in-flight entry
    do_reset();
    set_op(0, 32'h3F800000, 32'h40000000);
    req_valid = 4'b0011;
    #1;
    chk("midrst_first", 32'(req_ready), 32'h1);
    step();
    req_valid = 4'b0010;
    #1;
    chk("midrst_second", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("midrst_rsp_data", rsp_data, 32'h0);
    chk("midrst_op1", add_operand1, 32'h0);
    req_valid = 4'b0011;
    #1;
    chk("midrst_regrant", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    chk("midrst_no_rsp", 32'(rsp_valid), 32'h0);
    step();
    chk("midrst_new_rsp", rsp_data, 32'h40400000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
